fp_cvt: RTL and testbench
=========================

Name: fp_cvt

Overview:
- Converts a signed 32-bit two's-complement integer to an IEEE-754 binary32 float, like RISC-V FCVT.S.W.
- Sits in the FP execute path and is fully pipelined, so it accepts a new operand every cycle.
- Conversion logic is combinational: sign extraction, magnitude, leading-zero count, normalize, round.
- Result is captured in a single output register, giving 1-cycle latency.

Parameters:
- None. Widths are fixed at 32-bit input and binary32 output.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in  input  32  signed int32 operand (two's-complement bit pattern).
- res  output  32  binary32 result, registered.

Behaviour:
- Reset: when rst is high at a rising edge, res <= 32'h0000_0000. Reset has priority over the conversion result.
- Latency: res at edge N+1 reflects the value of in sampled at edge N.
  - No valid/ready handshake; the register updates every cycle.
  - A held input gives a stable output from the first edge onward.
- Sign: sign bit = in[31].
- Magnitude: mag = in[31] ? (~in + 1) : in, computed as an unsigned 32-bit value.
  - INT_MIN (32'h8000_0000) yields mag = 2^31 and must not be treated as positive or as zero.
- Zero: in == 0 -> res = 32'h0000_0000 (+0.0). A negative zero is never produced.
- Normalize:
  - lz = leading-zero count of mag (0..31); msb position p = 31 - lz.
  - Biased exponent = 127 + p, always in the range 127..158.
  - Overflow, infinity, NaN and denormal outputs are impossible.
- Mantissa: the 23 bits immediately below the leading 1.
  - For p <= 23 the mantissa is mag shifted left, exact, with no rounding.
  - For p > 23 the discarded low bits form guard, round and sticky bits.
- Rounding: round-to-nearest, ties-to-even, fixed with no rounding-mode input.
  - Round up when guard=1 and (round|sticky|mantissa LSB)=1.
  - If rounding carries out of the mantissa, the mantissa becomes 0 and the exponent increments by 1.
  - Example: 0x7FFFFFFF -> 2^31 = 32'h4F00_0000.
- No exception flags are output; inexact is not reported.
- Output packing: res = {sign, exp[7:0], mant[22:0]}.
- Reset mid-stream: the value in flight is discarded. The first post-reset result appears 1 edge after rst deasserts, for the then-current input.

Test Plan:
- Reset, special values and signs: rst high for 2 cycles -> res = 00000000.
  - Then 0 -> 00000000, 1 -> 3F800000, -1 -> BF800000, 2 -> 40000000, -2 -> C0000000.
- Small and medium exact integers, output checked 1 cycle after each apply:
  - 3 -> 40400000, 5 -> 40A00000, 10 -> 41200000, -10 -> C1200000, 15 -> 41700000.
  - 256 -> 43800000, -256 -> C3800000, 1024 -> 44800000.
- Extremes:
  - 32'h80000000 -> CF000000.
  - 16777216 (2^24) -> 4B800000.
  - 0x7FFFFFFF -> 4F000000 (rounding carries into the exponent).
- Rounding ties and non-ties:
  - 16777217 -> 4B800000 (tie, rounds to even, down).
  - 16777219 -> 4B800002 (tie, rounds to even, up).
  - 16777221 -> 4B800002 (tie, rounds to even, down).
  - 33554435 -> 4C000001 (above half, rounds up).
- Back-to-back throughput: apply a new operand every cycle (1, -1, 256, 32'h80000000).
  - res must show 3F800000, BF800000, 43800000, CF000000 on consecutive cycles, each 1 cycle after its input.
- Reset mid-operation: apply 5, assert rst on the next edge -> res = 00000000.
  - Deassert rst with in = 10 -> res = 41200000 one edge later.

Source files
------------

// File: rtl/fp_cvt.sv
// fp_cvt: signed int32 to IEEE-754 binary32 converter with one register stage.
// Rounds to nearest, ties to even. A new operand is accepted every cycle.
module fp_cvt (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in,
    output logic [31:0] res
);

    logic        sign;
    logic [31:0] mag;
    logic [4:0]  lz;
    logic [30:0] norm;
    logic [22:0] mant;
    logic        guard;
    logic        rnd;
    logic        sticky;
    logic        round_up;
    logic [23:0] mant_sum;
    logic [7:0]  exp_base;
    logic [7:0]  exp_final;
    logic [31:0] result;

    assign sign = in[31];

    // Two's-complement magnitude; INT_MIN wraps back to 2^31, which the unsigned view handles correctly
    assign mag = sign ? (~in + 32'd1) : in;

    // Leading-zero count: scanning upward lets the highest set bit write last and win
    always_comb begin
        lz = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (mag[i]) begin
                lz = 5'(31 - i);
            end
        end
    end

    // Shift the leading 1 up to bit 31 and drop it; it is the implicit bit
    assign norm = 31'(mag << lz);

    // Small operands leave the low bits zero, so the rounding terms vanish and the result is exact
    assign guard    = norm[7];
    assign rnd      = norm[6];
    assign sticky   = |norm[5:0];
    assign round_up = guard & (rnd | sticky | norm[8]);

    // A carry out of the 23-bit mantissa leaves its low bits zero and bumps the exponent
    assign mant_sum  = {1'b0, norm[30:8]} + {23'b0, round_up};
    assign mant      = mant_sum[22:0];
    assign exp_base  = 8'd158 - {3'b000, lz};
    assign exp_final = exp_base + {7'b0, mant_sum[23]};

    // Zero would otherwise look like 2^31 with a zero count, so it is forced to +0.0 here
    assign result = (in == 32'd0) ? 32'h0000_0000 : {sign, exp_final, mant};

    // Output register; reset takes priority over the conversion
    always_ff @(posedge clk) begin
        if (rst) begin
            res <= 32'h0000_0000;
        end else begin
            res <= result;
        end
    end

endmodule

// File: tb/tb_fp_cvt.sv
// tb_fp_cvt: directed and randomized bench for fp_cvt against an arithmetic reference model.
module tb_fp_cvt;

    logic        clk;
    logic        rst;
    logic [31:0] in;
    logic [31:0] res;

    int checks;
    int failures;

    fp_cvt dut (
        .clk (clk),
        .rst (rst),
        .in  (in),
        .res (res)
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference conversion from the integer value itself: find the power-of-two range,
    // divide down to 24 significant bits and round on the remainder
    function automatic logic [31:0] refConvert(input logic [31:0] v);
        logic   s;
        longint mag;
        longint q;
        longint rem;
        longint half;
        int     p;
        int     shift;
        if (v == 32'd0) begin
            return 32'h0000_0000;
        end
        s   = v[31];
        mag = longint'({32'b0, v});
        if (s) begin
            mag = 64'sd4294967296 - mag;
        end
        p = 0;
        while ((64'sd1 <<< (p + 1)) <= mag) begin
            p++;
        end
        if (p <= 23) begin
            q = mag * (64'sd1 <<< (23 - p));
        end else begin
            shift = p - 23;
            q     = mag / (64'sd1 <<< shift);
            rem   = mag - q * (64'sd1 <<< shift);
            half  = 64'sd1 <<< (shift - 1);
            if (rem > half || (rem == half && (q % 2) == 1)) begin
                q = q + 1;
            end
            if (q == (64'sd1 <<< 24)) begin
                q = q / 2;
                p = p + 1;
            end
        end
        return {s, 8'(127 + p), q[22:0]};
    endfunction

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %08h expected %08h", tag, actual, expected);
        end
    endtask

    // Drive an operand away from the edge, then sample the registered result just after the edge
    task automatic applyStimulus(input logic [31:0] value, input logic resetVal);
        @(negedge clk);
        in  = value;
        rst = resetVal;
        @(posedge clk);
        #1;
    endtask

    // Apply one operand and compare against a fixed expectation
    task automatic directed(input string tag, input logic [31:0] value, input logic [31:0] expected);
        applyStimulus(value, 1'b0);
        checkOutput(tag, res, expected);
    endtask

    initial begin
        logic [31:0] v;
        logic        r;
        int          mode;
        checks   = 0;
        failures = 0;
        in       = 32'd0;
        rst      = 1'b1;

        // Reset held for two edges
        applyStimulus(32'h1234_5678, 1'b1);
        applyStimulus(32'h1234_5678, 1'b1);
        checkOutput("reset", res, 32'h0000_0000);

        // Signs and special values
        directed("zero",   32'd0,          32'h0000_0000);
        directed("one",    32'd1,          32'h3F80_0000);
        directed("neg1",   32'hFFFF_FFFF,  32'hBF80_0000);
        directed("two",    32'd2,          32'h4000_0000);
        directed("neg2",   32'hFFFF_FFFE,  32'hC000_0000);

        // Small and medium exact integers
        directed("three",  32'd3,          32'h4040_0000);
        directed("five",   32'd5,          32'h40A0_0000);
        directed("ten",    32'd10,         32'h4120_0000);
        directed("neg10",  -32'sd10,       32'hC120_0000);
        directed("fifteen",32'd15,         32'h4170_0000);
        directed("p256",   32'd256,        32'h4380_0000);
        directed("n256",   -32'sd256,      32'hC380_0000);
        directed("p1024",  32'd1024,       32'h4480_0000);

        // Extremes
        directed("intmin", 32'h8000_0000,  32'hCF00_0000);
        directed("pow24",  32'd16777216,   32'h4B80_0000);
        directed("intmax", 32'h7FFF_FFFF,  32'h4F00_0000);

        // Rounding ties and non-ties
        directed("tie_dn1",32'd16777217,   32'h4B80_0000);
        directed("tie_up", 32'd16777219,   32'h4B80_0002);
        directed("tie_dn2",32'd16777221,   32'h4B80_0002);
        directed("above",  32'd33554435,   32'h4C00_0001);

        // Back-to-back throughput, one operand per cycle
        directed("b2b_1",  32'd1,          32'h3F80_0000);
        directed("b2b_n1", 32'hFFFF_FFFF,  32'hBF80_0000);
        directed("b2b_256",32'd256,        32'h4380_0000);
        directed("b2b_min",32'h8000_0000,  32'hCF00_0000);

        // Held input gives a stable output
        directed("hold_a", 32'd33554435,   32'h4C00_0001);
        directed("hold_b", 32'd33554435,   32'h4C00_0001);

        // Reset mid-operation discards the value in flight
        directed("mid_pre",32'd5,          32'h40A0_0000);
        applyStimulus(32'd7, 1'b1);
        checkOutput("mid_rst", res, 32'h0000_0000);
        directed("mid_post",32'd10,        32'h4120_0000);

        // Randomized operands with occasional reset pulses, checked against the model
        for (int n = 0; n < 400; n++) begin
            mode = int'($urandom_range(0, 3));
            case (mode)
                0: v = $urandom;
                1: v = 32'($signed($urandom_range(0, 2000)) - 1000);
                2: v = (32'd1 << $urandom_range(0, 31)) + 32'($signed($urandom_range(0, 4)) - 2);
                default: v = $urandom & ((32'd1 << $urandom_range(1, 31)) - 32'd1);
            endcase
            r = ($urandom_range(0, 19) == 0);
            applyStimulus(v, r);
            checkOutput(r ? "rand_rst" : "random", res, r ? 32'h0000_0000 : refConvert(v));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
